// File: rtl/fofb_readout_streamer_pkg.sv
// Shared definitions for the FOFB readout streamer: FSM state encoding,
// record lane layout ({S, Y, X} MSB to LSB) and the lane-width helper.
// Latency: n/a (declarations only). Backpressure: n/a.
package fofb_readout_streamer_pkg;

  // TRAIL is only reachable when FOFB_STREAMER_TRAILER_EN is defined.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_TRAIL = 2'd3
  } state_e;

  localparam int NUM_LANES = 3;

  // Lane position within a record, counted from the LSB.
  typedef enum int {
    LANE_X = 0,
    LANE_Y = 1,
    LANE_S = 2
  } lane_e;

  function automatic int lane_width(input int data_width);
    return data_width / NUM_LANES;
  endfunction

endpackage

// File: rtl/fofb_readout_streamer_if.sv
// Valid/ready record stream from the readout streamer to the FOFB DSP/packetizer.
// Latency: n/a (wires only). Backpressure: beat held while m_valid && !m_ready.
// Ports: m_valid/m_data/m_index/m_last driven by master, m_ready by slave.
interface fofb_readout_streamer_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 96
);
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic [ADDR_WIDTH-1:0] m_index;
  logic                  m_last;

  modport master (output m_valid, output m_data, output m_index, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_index, input m_last, output m_ready);
endinterface

// File: rtl/fofb_stream_fifo.sv
// First-word-fall-through FIFO with occupancy output for credit accounting.
// Latency: push visible at pop_dat the cycle after the write edge.
// Backpressure: none internally; caller must not push when full (credits guarantee this).
// Ports: clk, rst_n (async active-low), push/push_dat, pop/pop_dat, empty, occ.
module fofb_stream_fifo #(
  parameter int WIDTH = 105,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_dat,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_dat,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   occ
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]    occ_q, occ_d;
  logic             full, push_ok, pop_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (occ_q == '0);
  assign full    = (occ_q == OW'(DEPTH));
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign pop_dat = mem_q[rd_ptr_q];
  assign occ     = occ_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop_ok) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    occ_d = occ_q + OW'(push_ok) - OW'(pop_ok);
  end

  // Storage is reset so the stream data/index outputs come up as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end
endmodule

// File: rtl/fofb_readout_streamer.sv
// Scans RAM records 0..count-1 over a registered read port and streams them in order.
// Latency: start edge t0 -> addrb=0 after t0, first m_valid after t0+2, done after last pop.
// Backpressure: reads issue only while FIFO occupancy + in-flight reads < FIFO_DEPTH; no beats lost.
// Ports: clk, resetn (async active-low), start/count, busy/done, addrb/doutb (RAM port B),
//        m_if (stream master). Optional feature: FOFB_STREAMER_TRAILER_EN appends an XOR trailer beat.
module fofb_readout_streamer
  import fofb_readout_streamer_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 96,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    start,
  input  logic [ADDR_WIDTH:0]     count,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_WIDTH-1:0]   addrb,
  input  logic [DATA_WIDTH-1:0]   doutb,
  fofb_readout_streamer_if.master m_if
);
  localparam int CW = ADDR_WIDTH + 1;
  localparam int OW = $clog2(FIFO_DEPTH + 1);
  localparam int FW = DATA_WIDTH + ADDR_WIDTH;
  localparam logic [CW-1:0] MAX_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_e                state_q, state_d;
  logic [CW-1:0]         count_q, count_d, rd_ptr_q, rd_ptr_d, count_clamped;
  logic [ADDR_WIDTH-1:0] addrb_q, addrb_d, idx_s2_q, idx_s2_d, last_idx, head_idx;
  logic                  rd_s1_q, rd_s1_d, rd_s2_q, rd_s2_d, done_q, done_d;
  logic [DATA_WIDTH-1:0] head_dat;
  logic [FW-1:0]         fifo_in, fifo_out;
  logic [OW-1:0]         fifo_occ;
  logic                  fifo_empty, fifo_pop, issue, credit_ok, start_ok, last_pop;

  assign count_clamped = (count > MAX_CNT) ? MAX_CNT : count;
  assign start_ok      = start && (state_q == ST_IDLE) && (count_clamped != '0);

  // rd_s1: address on addrb this cycle; rd_s2: its data on doutb this cycle.
  // Both are reads the FIFO has already promised a slot to.
  assign credit_ok = (32'(fifo_occ) + 32'(rd_s1_q) + 32'(rd_s2_q)) < 32'(FIFO_DEPTH);
  // The accepting edge issues address 0 itself, so addrb=0 lands with busy.
  assign issue     = start_ok || ((state_q == ST_RUN) && credit_ok);

  assign last_idx  = ADDR_WIDTH'(count_q - 1'b1);
  assign fifo_in   = {idx_s2_q, doutb};
  assign head_idx  = fifo_out[FW-1 -: ADDR_WIDTH];
  assign head_dat  = fifo_out[DATA_WIDTH-1:0];
  assign fifo_pop  = !fifo_empty && m_if.m_ready;
  assign last_pop  = fifo_pop && (head_idx == last_idx);

  fofb_stream_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (resetn),
    .push     (rd_s2_q),
    .push_dat (fifo_in),
    .pop      (fifo_pop),
    .pop_dat  (fifo_out),
    .empty    (fifo_empty),
    .occ      (fifo_occ)
  );

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_ok) state_d = (count_clamped == CW'(1)) ? ST_DRAIN : ST_RUN;
      ST_RUN:   if (issue && (rd_ptr_q == count_q - 1'b1)) state_d = ST_DRAIN;
`ifdef FOFB_STREAMER_TRAILER_EN
      ST_DRAIN: if (last_pop) state_d = ST_TRAIL;
`else
      ST_DRAIN: if (last_pop) state_d = ST_IDLE;
`endif
      ST_TRAIL: if (m_if.m_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output logic: done is registered so it pulses in the IDLE-entry cycle.
  always_comb begin
    done_d = (start && (state_q == ST_IDLE) && (count_clamped == '0)) ||
             ((state_q != ST_IDLE) && (state_d == ST_IDLE));
  end

  assign busy  = (state_q != ST_IDLE);
  assign done  = done_q;
  assign addrb = addrb_q;

  // Read pointer and read pipeline
  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    addrb_d  = addrb_q;
    if (start_ok) begin
      count_d  = count_clamped;
      addrb_d  = '0;
      rd_ptr_d = CW'(1);
    end else if (issue) begin
      addrb_d  = rd_ptr_q[ADDR_WIDTH-1:0];
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    rd_s1_d  = issue;
    rd_s2_d  = rd_s1_q;
    idx_s2_d = addrb_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      addrb_q  <= '0;
      rd_s1_q  <= 1'b0;
      rd_s2_q  <= 1'b0;
      idx_s2_q <= '0;
      done_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      addrb_q  <= addrb_d;
      rd_s1_q  <= rd_s1_d;
      rd_s2_q  <= rd_s2_d;
      idx_s2_q <= idx_s2_d;
      done_q   <= done_d;
    end
  end

`ifdef FOFB_STREAMER_TRAILER_EN
  localparam int LW = lane_width(DATA_WIDTH);
  logic [DATA_WIDTH-1:0] acc_q, acc_d;

  // Lane-wise XOR of every record beat that leaves the FIFO.
  always_comb begin
    acc_d = acc_q;
    if (start_ok) begin
      acc_d = '0;
    end else if (fifo_pop) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        acc_d[l*LW +: LW] = acc_q[l*LW +: LW] ^ head_dat[l*LW +: LW];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) acc_q <= '0;
    else         acc_q <= acc_d;
  end

  assign m_if.m_valid = !fifo_empty || (state_q == ST_TRAIL);
  assign m_if.m_data  = (state_q == ST_TRAIL) ? acc_q : head_dat;
  assign m_if.m_index = (state_q == ST_TRAIL) ? count_q[ADDR_WIDTH-1:0] : head_idx;
  assign m_if.m_last  = (state_q == ST_TRAIL);
`else
  assign m_if.m_valid = !fifo_empty;
  assign m_if.m_data  = head_dat;
  assign m_if.m_index = head_idx;
  assign m_if.m_last  = !fifo_empty && (head_idx == last_idx);
`endif

endmodule
